// File: rtl/mac_scheduler_if.sv
// Datapath and result-stream bundle between the MAC scheduler and its
// surroundings. The master side is the scheduler. It drives the operand
// fetch and accumulate controls and presents results. The slave side is
// the MAC datapath together with the result consumer.
interface mac_scheduler_if #(
  parameter int ACC_W = 19
);
  logic             mac_en;
  logic             acc_clr;
  logic [3:0]       term_idx;
  logic [7:0]       out_idx;
  logic [ACC_W-1:0] mac_res;
  logic             res_valid;
  logic [ACC_W-1:0] res_data;
  logic             res_ready;

  modport master (
    output mac_en, acc_clr, term_idx, out_idx, res_valid, res_data,
    input  mac_res, res_ready
  );

  modport slave (
    input  mac_en, acc_clr, term_idx, out_idx, res_valid, res_data,
    output mac_res, res_ready
  );
endinterface

// File: rtl/mac_scheduler.sv
// MAC job sequencer. A job is n_out windows of k_len multiply-accumulate
// terms each. After the last term of a window, the sequencer waits LAT
// cycles for the datapath, then captures the sum into a single-entry
// valid/ready output slot. If the slot is still occupied at that point,
// the sum is parked in a hold register and the sequencer stalls until the
// slot frees up. LAT must be at least 1.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no job; waits for a start with legal k_len / n_out
// ISSUE | one MAC term per cycle; term_idx counts 0..k_len-1
// DRAIN | waits LAT cycles for the datapath result; samples on count 1
// HOLD  | result parked; waits for the output slot to free
// DONE  | single-cycle completion pulse
module mac_scheduler #(
  parameter int LAT   = 2,
  parameter int ACC_W = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] k_len,
  input  logic [7:0] n_out,
  output logic       busy,
  output logic       done,
  mac_scheduler_if.master dp
);

  localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [4:0]       k_lat;
  logic [7:0]       n_lat;
  logic [3:0]       term_idx;
  logic [7:0]       out_idx;
  logic [CNT_W-1:0] drain_cnt;
  logic [ACC_W-1:0] hold_q;
  logic [ACC_W-1:0] res_data_q;
  logic             res_valid_q;

  logic accept, last_term, last_win, slot_free, sample, load_new, load_hold, load;
  logic mac_en_c, acc_clr_c, busy_c, done_c;

  // k_len above 16 would overflow term_idx, so it is rejected just like zero.
  assign accept    = start && (k_len != 5'd0) && (k_len <= 5'd16) && (n_out != 8'd0);
  assign last_term = ({1'b0, term_idx} == (k_lat - 5'd1));
  assign last_win  = (out_idx == (n_lat - 8'd1));
  assign slot_free = !res_valid_q || dp.res_ready;
  assign sample    = (state == DRAIN) && (drain_cnt == CNT_W'(1));
  assign load_new  = sample && slot_free;
  assign load_hold = (state == HOLD) && slot_free;
  assign load      = load_new || load_hold;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    mac_en_c  = 1'b0;
    acc_clr_c = 1'b0;
    busy_c    = 1'b1;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        mac_en_c  = 1'b1;
        acc_clr_c = (term_idx == 4'd0);
        if (last_term) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (sample) begin
          if (!slot_free)    state_nxt = HOLD;
          else if (last_win) state_nxt = DONE;
          else               state_nxt = ISSUE;
        end
      end
      HOLD: begin
        if (slot_free) state_nxt = last_win ? DONE : ISSUE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job parameters, window/term counters and the drain timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_lat     <= '0;
      n_lat     <= '0;
      term_idx  <= '0;
      out_idx   <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            k_lat    <= k_len;
            n_lat    <= n_out;
            term_idx <= '0;
            out_idx  <= '0;
          end
        end
        ISSUE: begin
          if (last_term) begin
            term_idx  <= '0;
            drain_cnt <= CNT_W'(LAT);
          end else begin
            term_idx <= term_idx + 4'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt != '0) drain_cnt <= drain_cnt - CNT_W'(1);
        end
        default: ;
      endcase
      // The last window's index stays put so it never wraps past n_out-1.
      if (load && !last_win) out_idx <= out_idx + 8'd1;
    end
  end

  // Output slot and hold register. A load in the same cycle as a handshake
  // keeps res_valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q      <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      if (sample && !slot_free) hold_q <= dp.mac_res;
      if (load) begin
        res_data_q  <= load_new ? dp.mac_res : hold_q;
        res_valid_q <= 1'b1;
      end else if (dp.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign busy         = busy_c;
  assign done         = done_c;
  assign dp.mac_en    = mac_en_c;
  assign dp.acc_clr   = acc_clr_c;
  assign dp.term_idx  = term_idx;
  assign dp.out_idx   = out_idx;
  assign dp.res_valid = res_valid_q;
  assign dp.res_data  = res_data_q;

endmodule

// File: tb/tb_mac_scheduler.sv
// Directed bench for mac_scheduler. A small datapath model accumulates
// operand = 16*out_idx + term_idx + 1 and presents the sum one register
// later, which matches LAT = 2. Expected window sums are written out as
// constants.
module tb_mac_scheduler;
  localparam int ACC_W = 19;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] k_len = '0;
  logic [7:0] n_out = '0;
  logic       busy, done;

  mac_scheduler_if #(.ACC_W(ACC_W)) ifc ();

  mac_scheduler #(.LAT(2), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .k_len (k_len),
    .n_out (n_out),
    .busy  (busy),
    .done  (done),
    .dp    (ifc.master)
  );

  always #5 clk = ~clk;

  logic [ACC_W-1:0] acc = '0;
  logic [ACC_W-1:0] pipe = '0;
  logic [ACC_W-1:0] op;
  assign op = ACC_W'({ifc.out_idx, 4'b0000}) + ACC_W'(ifc.term_idx) + ACC_W'(1);

  // Datapath model: accumulate on mac_en, then one output register.
  always @(posedge clk) begin
    if (ifc.mac_en) acc <= ifc.acc_clr ? op : acc + op;
    pipe <= acc;
  end
  assign ifc.mac_res = pipe;

  int nchk = 0;
  int nerr = 0;
  int g_en, g_clr, g_done, g_busy, g_to;
  int res_q[$];
  int out_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe the DUT from the current cycle until it is idle with an empty
  // output slot, or until the budget runs out.
  task automatic run_job(input int budget);
    g_en = 0; g_clr = 0; g_done = 0; g_busy = 0; g_to = 1;
    res_q.delete();
    out_q.delete();
    for (int i = 0; i < budget; i++) begin
      if (!busy && !ifc.res_valid) begin
        g_to = 0;
        break;
      end
      if (busy) g_busy++;
      if (ifc.mac_en) g_en++;
      if (ifc.acc_clr) begin
        g_clr++;
        out_q.push_back(int'(ifc.out_idx));
      end
      if (done) g_done++;
      if (ifc.res_valid && ifc.res_ready) res_q.push_back(int'(ifc.res_data));
      tick();
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    ifc.res_ready = 1'b0;

    // Reset state
    #1;
    chk("reset_outputs", {busy, ifc.mac_en, ifc.acc_clr, ifc.res_valid, done,
                          ifc.term_idx, ifc.out_idx}, 0);
    chk("reset_res_data", ifc.res_data, 0);
    tick(); tick();
    rst = 1'b1;

    // k_len=3, n_out=2, ready high
    ifc.res_ready = 1'b1;
    start = 1'b1; k_len = 5'd3; n_out = 8'd2;
    tick();
    start = 1'b0;
    chk("t1_c0_busy", busy, 1);
    chk("t1_c0_acc_clr", ifc.acc_clr, 1);
    chk("t1_c0_term", ifc.term_idx, 0);
    tick();
    chk("t1_c1_acc_clr", ifc.acc_clr, 0);
    chk("t1_c1_term", ifc.term_idx, 1);
    run_job(40);
    chk("t1_timeout", g_to, 0);
    chk("t1_mac_en_cycles", g_en, 5);
    chk("t1_acc_clr_cycles", g_clr, 1);
    chk("t1_busy_cycles", g_busy, 10);
    chk("t1_done_pulses", g_done, 1);
    chk("t1_n_results", res_q.size(), 2);
    if (res_q.size() == 2) begin
      chk("t1_res0", res_q[0], 6);
      chk("t1_res1", res_q[1], 54);
    end

    // k_len=1, n_out=4
    start = 1'b1; k_len = 5'd1; n_out = 8'd4;
    tick();
    start = 1'b0;
    chk("t2_c0_en_clr", {ifc.mac_en, ifc.acc_clr}, 2'b11);
    run_job(60);
    chk("t2_timeout", g_to, 0);
    chk("t2_mac_en_cycles", g_en, 4);
    chk("t2_busy_cycles", g_busy, 13);
    chk("t2_done_pulses", g_done, 1);
    chk("t2_n_results", res_q.size(), 4);
    chk("t2_n_windows", out_q.size(), 4);
    if (res_q.size() == 4 && out_q.size() == 4) begin
      chk("t2_res0", res_q[0], 1);
      chk("t2_res1", res_q[1], 17);
      chk("t2_res2", res_q[2], 33);
      chk("t2_res3", res_q[3], 49);
      chk("t2_out0", out_q[0], 0);
      chk("t2_out1", out_q[1], 1);
      chk("t2_out2", out_q[2], 2);
      chk("t2_out3", out_q[3], 3);
    end

    // Illegal starts: k_len=0, then n_out=0
    start = 1'b1; k_len = 5'd0; n_out = 8'd3;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy || ifc.mac_en || done) bad++;
    end
    chk("t3_klen0_activity", bad, 0);
    k_len = 5'd4; n_out = 8'd0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy || ifc.mac_en || done) bad++;
    end
    chk("t3_nout0_activity", bad, 0);
    start = 1'b0;

    // Restart attempt while busy must not disturb the job
    start = 1'b1; k_len = 5'd4; n_out = 8'd1;
    tick();
    k_len = 5'd9; n_out = 8'd3;
    chk("t4_c0_term", ifc.term_idx, 0);
    tick();
    start = 1'b0; k_len = 5'd0; n_out = 8'd0;
    chk("t4_c1_term", ifc.term_idx, 1);
    run_job(40);
    chk("t4_timeout", g_to, 0);
    chk("t4_mac_en_cycles", g_en, 3);
    chk("t4_busy_cycles", g_busy, 6);
    chk("t4_done_pulses", g_done, 1);
    chk("t4_n_results", res_q.size(), 1);
    if (res_q.size() == 1) chk("t4_res0", res_q[0], 10);

    // k_len=16, n_out=2 with back-pressure
    ifc.res_ready = 1'b0;
    start = 1'b1; k_len = 5'd16; n_out = 8'd2;
    tick();
    start = 1'b0;
    repeat (15) tick();
    chk("t5_c15_term_max", ifc.term_idx, 15);
    chk("t5_c15_en", ifc.mac_en, 1);
    repeat (21) tick();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (ifc.mac_en || done || !busy) bad++;
      tick();
    end
    chk("t5_hold_quiet", bad, 0);
    chk("t5_hold_valid", ifc.res_valid, 1);
    chk("t5_hold_data", ifc.res_data, 136);
    ifc.res_ready = 1'b1;
    run_job(20);
    chk("t5_timeout", g_to, 0);
    chk("t5_done_pulses", g_done, 1);
    chk("t5_mac_en_cycles", g_en, 0);
    chk("t5_n_results", res_q.size(), 2);
    if (res_q.size() == 2) begin
      chk("t5_res0", res_q[0], 136);
      chk("t5_res1", res_q[1], 392);
    end

    // Reset in the middle of window 2
    ifc.res_ready = 1'b0;
    start = 1'b1; k_len = 5'd8; n_out = 8'd5;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("t6_pre_term", ifc.term_idx, 2);
    chk("t6_pre_out", ifc.out_idx, 1);
    chk("t6_pre_valid", ifc.res_valid, 1);
    chk("t6_pre_data", ifc.res_data, 36);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_outputs", {busy, ifc.mac_en, ifc.acc_clr, ifc.res_valid, done,
                             ifc.term_idx, ifc.out_idx}, 0);
    chk("t6_async_res_data", ifc.res_data, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done || busy) bad++;
    end
    chk("t6_quiet_in_reset", bad, 0);
    rst = 1'b1;
    ifc.res_ready = 1'b1;
    start = 1'b1; k_len = 5'd2; n_out = 8'd1;
    tick();
    start = 1'b0;
    chk("t6_first_edge_start", {busy, ifc.mac_en, ifc.acc_clr}, 3'b111);
    run_job(30);
    chk("t6_timeout", g_to, 0);
    chk("t6_mac_en_cycles", g_en, 2);
    chk("t6_done_pulses", g_done, 1);
    chk("t6_n_results", res_q.size(), 1);
    if (res_q.size() == 1) chk("t6_res0", res_q[0], 3);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
